// File: rtl/forward_scoreboard_if.sv
// forward_scoreboard_if
// Groups the decode-stage instruction fields presented to the scoreboard and
// the hazard/forwarding decisions it returns.
//   master : drives the D-stage fields, receives stall / fwd_* / md_busy
//   slave  : the scoreboard side (receives D fields, drives decisions)
interface forward_scoreboard_if #(
    parameter int AW = 5,
    parameter int TW = 2
);
    logic [AW-1:0] d_rs;
    logic [AW-1:0] d_rt;
    logic          d_rs_use;
    logic          d_rt_use;
    logic [TW-1:0] d_rs_tuse;
    logic [TW-1:0] d_rt_tuse;
    logic          d_wen;
    logic [AW-1:0] d_dst;
    logic [TW-1:0] d_tnew;
    logic          d_md;
    logic          d_md_div;
    logic          d_md_use;

    logic          stall;
    logic [1:0]    fwd_d_rs;
    logic [1:0]    fwd_d_rt;
    logic [1:0]    fwd_e_rs;
    logic [1:0]    fwd_e_rt;
    logic          fwd_m_rt;
    logic          md_busy;

    modport master (
        output d_rs, d_rt, d_rs_use, d_rt_use, d_rs_tuse, d_rt_tuse,
               d_wen, d_dst, d_tnew, d_md, d_md_div, d_md_use,
        input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, md_busy
    );

    modport slave (
        input  d_rs, d_rt, d_rs_use, d_rt_use, d_rs_tuse, d_rt_tuse,
               d_wen, d_dst, d_tnew, d_md, d_md_div, d_md_use,
        output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, md_busy
    );
endinterface

// File: rtl/forward_scoreboard.sv
// forward_scoreboard
// Tnew/Tuse hazard scoreboard for a 5-stage pipeline. Tracks the producers
// sitting in E, M and W, decides the D-stage stall, and selects forwarding
// sources for the D, E and M operands. Also tracks mult/div occupancy.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low; clears all records and the md counter
//   sb    : forward_scoreboard_if.slave (D-stage fields in, decisions out)
//           fwd_d_*: 0 regfile, 1 W, 2 M, 3 E
//           fwd_e_*: 0 pipe register, 1 W, 2 M
//           fwd_m_rt: 0 pipe register, 1 W
module forward_scoreboard #(
    parameter int AW       = 5,
    parameter int TW       = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    forward_scoreboard_if.slave  sb
);
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    // Producer records
    logic          e_valid, e_rs_use, e_rt_use;
    logic [AW-1:0] e_dst, e_rs, e_rt;
    logic [TW-1:0] e_tnew;
    logic          m_valid, m_rt_use;
    logic [AW-1:0] m_dst, m_rt;
    logic [TW-1:0] m_tnew;
    logic          w_valid;
    logic [AW-1:0] w_dst;
    logic [TW-1:0] w_tnew;

    logic [CW-1:0] md_cnt;
    logic          md_busy;
    logic          stall;

    logic [2:0]    rs_d_pick, rt_d_pick;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    function automatic logic hit(input logic v, input logic u,
                                 input logic [AW-1:0] a, input logic [AW-1:0] d);
        return v & u & (a == d) & (a != '0);
    endfunction

    // {hazard, select}: only the nearest matching producer is considered,
    // so a younger producer with nonzero tnew blocks an older ready one.
    function automatic logic [2:0] d_pick(input logic [AW-1:0] a, input logic u,
                                          input logic [TW-1:0] tuse);
        logic       haz;
        logic [1:0] sel;
        haz = 1'b0;
        sel = 2'd0;
        if (hit(e_valid, u, a, e_dst)) begin
            haz = (e_tnew > tuse);
            sel = (e_tnew == '0) ? 2'd3 : 2'd0;
        end else if (hit(m_valid, u, a, m_dst)) begin
            haz = (m_tnew > tuse);
            sel = (m_tnew == '0) ? 2'd2 : 2'd0;
        end else if (hit(w_valid, u, a, w_dst)) begin
            haz = (w_tnew > tuse);
            sel = (w_tnew == '0) ? 2'd1 : 2'd0;
        end
        return {haz, sel};
    endfunction

    function automatic logic [1:0] e_pick(input logic [AW-1:0] a, input logic u);
        logic [1:0] sel;
        sel = 2'd0;
        if (hit(m_valid, u, a, m_dst))
            sel = (m_tnew == '0) ? 2'd2 : 2'd0;
        else if (hit(w_valid, u, a, w_dst))
            sel = (w_tnew == '0) ? 2'd1 : 2'd0;
        return sel;
    endfunction

    assign md_busy = (md_cnt != '0);

    always_comb begin
        rs_d_pick = d_pick(sb.d_rs, sb.d_rs_use, sb.d_rs_tuse);
        rt_d_pick = d_pick(sb.d_rt, sb.d_rt_use, sb.d_rt_tuse);
        stall     = rs_d_pick[2] | rt_d_pick[2] |
                    ((sb.d_md | sb.d_md_use) & md_busy);
    end

    assign sb.stall    = stall;
    assign sb.md_busy  = md_busy;
    assign sb.fwd_d_rs = rs_d_pick[1:0];
    assign sb.fwd_d_rt = rt_d_pick[1:0];
    assign sb.fwd_e_rs = e_pick(e_rs, e_rs_use);
    assign sb.fwd_e_rt = e_pick(e_rt, e_rt_use);
    assign sb.fwd_m_rt = hit(w_valid, m_rt_use, m_rt, w_dst) & (w_tnew == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_valid  <= 1'b0;
            e_rs_use <= 1'b0;
            e_rt_use <= 1'b0;
            e_dst    <= '0;
            e_rs     <= '0;
            e_rt     <= '0;
            e_tnew   <= '0;
            m_valid  <= 1'b0;
            m_rt_use <= 1'b0;
            m_dst    <= '0;
            m_rt     <= '0;
            m_tnew   <= '0;
            w_valid  <= 1'b0;
            w_dst    <= '0;
            w_tnew   <= '0;
        end else begin
            w_valid  <= m_valid;
            w_dst    <= m_dst;
            w_tnew   <= sat_dec(m_tnew);
            m_valid  <= e_valid;
            m_dst    <= e_dst;
            m_tnew   <= sat_dec(e_tnew);
            m_rt     <= e_rt;
            m_rt_use <= e_rt_use;
            if (stall) begin
                e_valid  <= 1'b0;
                e_rs_use <= 1'b0;
                e_rt_use <= 1'b0;
                e_dst    <= '0;
                e_rs     <= '0;
                e_rt     <= '0;
                e_tnew   <= '0;
            end else begin
                e_valid  <= sb.d_wen & (sb.d_dst != '0);
                e_rs_use <= sb.d_rs_use;
                e_rt_use <= sb.d_rt_use;
                e_dst    <= sb.d_dst;
                e_rs     <= sb.d_rs;
                e_rt     <= sb.d_rt;
                e_tnew   <= sb.d_tnew;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            md_cnt <= '0;
        else if (sb.d_md && !stall)
            md_cnt <= sb.d_md_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
        else if (md_cnt != '0)
            md_cnt <= md_cnt - CW'(1);
    end
endmodule

// File: tb/tb_forward_scoreboard.sv
module tb_forward_scoreboard;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    forward_scoreboard_if #(.AW(5), .TW(2)) sb_if ();

    forward_scoreboard #(
        .AW(5), .TW(2), .MULT_LAT(5), .DIV_LAT(10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [4:0] rs, input logic rs_use, input logic [1:0] rs_tuse,
                         input logic [4:0] rt, input logic rt_use, input logic [1:0] rt_tuse,
                         input logic wen, input logic [4:0] dst, input logic [1:0] tnew,
                         input logic md, input logic md_div, input logic md_use);
        sb_if.d_rs      = rs;
        sb_if.d_rs_use  = rs_use;
        sb_if.d_rs_tuse = rs_tuse;
        sb_if.d_rt      = rt;
        sb_if.d_rt_use  = rt_use;
        sb_if.d_rt_tuse = rt_tuse;
        sb_if.d_wen     = wen;
        sb_if.d_dst     = dst;
        sb_if.d_tnew    = tnew;
        sb_if.d_md      = md;
        sb_if.d_md_div  = md_div;
        sb_if.d_md_use  = md_use;
    endtask

    task automatic idle();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic flush();
        idle();
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        #1 reset = 1'b0;
        #1;
        total++; if (sb_if.stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0d want=0", sb_if.stall); end
        total++; if (sb_if.md_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0d want=0", sb_if.md_busy); end
        total++; if ({sb_if.fwd_d_rs, sb_if.fwd_d_rt, sb_if.fwd_e_rs, sb_if.fwd_e_rt, sb_if.fwd_m_rt} !== 9'd0) begin
            bad++; $display("FAIL rst_fwd got=%0h want=0", {sb_if.fwd_d_rs, sb_if.fwd_d_rt, sb_if.fwd_e_rs, sb_if.fwd_e_rt, sb_if.fwd_m_rt});
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        total++; if (sb_if.stall !== 1'b0) begin bad++; $display("FAIL post_rst_stall got=%0d want=0", sb_if.stall); end
    endtask

    task automatic test_alu_fwd();
        flush();
        set_d(0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0);          // addu $3
        tick();
        set_d(3, 1, 1, 0, 0, 0, 1, 4, 1, 0, 0, 0);          // addu $4 <- $3
        #1;
        total++; if (sb_if.stall !== 1'b0) begin bad++; $display("FAIL alu_stall got=%0d want=0", sb_if.stall); end
        total++; if (sb_if.fwd_d_rs !== 2'd0) begin bad++; $display("FAIL alu_fwd_d_e_t1 got=%0d want=0", sb_if.fwd_d_rs); end
        tick();
        set_d(3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);          // reader of $3
        #1;
        total++; if (sb_if.fwd_e_rs !== 2'd2) begin bad++; $display("FAIL alu_fwd_e_m got=%0d want=2", sb_if.fwd_e_rs); end
        total++; if (sb_if.fwd_d_rs !== 2'd2) begin bad++; $display("FAIL alu_fwd_d_m got=%0d want=2", sb_if.fwd_d_rs); end
        total++; if (sb_if.fwd_e_rt !== 2'd0) begin bad++; $display("FAIL alu_fwd_e_rt got=%0d want=0", sb_if.fwd_e_rt); end
        tick();
        idle();
        #1;
        total++; if (sb_if.fwd_e_rs !== 2'd1) begin bad++; $display("FAIL alu_fwd_e_w got=%0d want=1", sb_if.fwd_e_rs); end
    endtask

    task automatic test_load_use();
        flush();
        set_d(0, 0, 0, 0, 0, 0, 1, 5, 2, 0, 0, 0);          // lw $5
        #1;
        total++; if (sb_if.stall !== 1'b0) begin bad++; $display("FAIL lw_issue_stall got=%0d want=0", sb_if.stall); end
        tick();
        set_d(5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);          // beq $5
        #1;
        total++; if (sb_if.stall !== 1'b1) begin bad++; $display("FAIL lu_stall_e got=%0d want=1", sb_if.stall); end
        total++; if (sb_if.fwd_d_rs !== 2'd0) begin bad++; $display("FAIL lu_fwd_e got=%0d want=0", sb_if.fwd_d_rs); end
        tick();
        #1;
        total++; if (sb_if.stall !== 1'b1) begin bad++; $display("FAIL lu_stall_m got=%0d want=1", sb_if.stall); end
        tick();
        #1;
        total++; if (sb_if.stall !== 1'b0) begin bad++; $display("FAIL lu_release got=%0d want=0", sb_if.stall); end
        total++; if (sb_if.fwd_d_rs !== 2'd1) begin bad++; $display("FAIL lu_fwd_w got=%0d want=1", sb_if.fwd_d_rs); end
    endtask

    task automatic test_store_fwd();
        flush();
        set_d(0, 0, 0, 0, 0, 0, 1, 6, 2, 0, 0, 0);          // lw $6
        tick();
        set_d(0, 0, 0, 6, 1, 2, 0, 0, 0, 0, 0, 0);          // sw $6
        #1;
        total++; if (sb_if.stall !== 1'b0) begin bad++; $display("FAIL st_stall got=%0d want=0", sb_if.stall); end
        total++; if (sb_if.fwd_d_rt !== 2'd0) begin bad++; $display("FAIL st_fwd_d got=%0d want=0", sb_if.fwd_d_rt); end
        tick();
        idle();
        #1;
        total++; if (sb_if.fwd_e_rt !== 2'd0) begin bad++; $display("FAIL st_fwd_e_m_t1 got=%0d want=0", sb_if.fwd_e_rt); end
        tick();
        #1;
        total++; if (sb_if.fwd_m_rt !== 1'b1) begin bad++; $display("FAIL st_fwd_m got=%0d want=1", sb_if.fwd_m_rt); end
        tick();
        #1;
        total++; if (sb_if.fwd_m_rt !== 1'b0) begin bad++; $display("FAIL st_fwd_m_clear got=%0d want=0", sb_if.fwd_m_rt); end
    endtask

    task automatic test_jal();
        flush();
        set_d(0, 0, 0, 0, 0, 0, 1, 31, 0, 0, 0, 0);         // jal
        tick();
        set_d(31, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);         // jr $31
        #1;
        total++; if (sb_if.stall !== 1'b0) begin bad++; $display("FAIL jal_stall got=%0d want=0", sb_if.stall); end
        total++; if (sb_if.fwd_d_rs !== 2'd3) begin bad++; $display("FAIL jal_fwd_e got=%0d want=3", sb_if.fwd_d_rs); end
    endtask

    task automatic test_zero_nouse();
        flush();
        set_d(0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0);          // writes $0
        tick();
        set_d(0, 1, 0, 0, 0, 0, 1, 7, 2, 0, 0, 0);          // reads $0, writes $7
        #1;
        total++; if (sb_if.stall !== 1'b0) begin bad++; $display("FAIL zero_stall got=%0d want=0", sb_if.stall); end
        total++; if (sb_if.fwd_d_rs !== 2'd0) begin bad++; $display("FAIL zero_fwd got=%0d want=0", sb_if.fwd_d_rs); end
        tick();
        set_d(7, 0, 0, 7, 1, 2, 0, 0, 0, 0, 0, 0);          // rs=$7 unused, rt=$7 tuse 2
        #1;
        total++; if (sb_if.stall !== 1'b0) begin bad++; $display("FAIL nouse_stall got=%0d want=0", sb_if.stall); end
        total++; if (sb_if.fwd_d_rs !== 2'd0) begin bad++; $display("FAIL nouse_fwd got=%0d want=0", sb_if.fwd_d_rs); end
    endtask

    task automatic test_md();
        flush();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);          // div
        #1;
        total++; if (sb_if.stall !== 1'b0) begin bad++; $display("FAIL div_issue_stall got=%0d want=0", sb_if.stall); end
        total++; if (sb_if.md_busy !== 1'b0) begin bad++; $display("FAIL div_issue_busy got=%0d want=0", sb_if.md_busy); end
        tick();
        for (int i = 0; i < 10; i++) begin
            if (i < 5) set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);   // mfhi
            else       set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);   // mult
            #1;
            total++; if (sb_if.md_busy !== 1'b1) begin bad++; $display("FAIL div_busy[%0d] got=%0d want=1", i, sb_if.md_busy); end
            total++; if (sb_if.stall !== 1'b1) begin bad++; $display("FAIL div_stall[%0d] got=%0d want=1", i, sb_if.stall); end
            tick();
        end
        #1;
        total++; if (sb_if.md_busy !== 1'b0) begin bad++; $display("FAIL div_done_busy got=%0d want=0", sb_if.md_busy); end
        total++; if (sb_if.stall !== 1'b0) begin bad++; $display("FAIL mult_release got=%0d want=0", sb_if.stall); end
        tick();
        idle();
        for (int j = 0; j < 5; j++) begin
            #1;
            total++; if (sb_if.md_busy !== 1'b1) begin bad++; $display("FAIL mult_busy[%0d] got=%0d want=1", j, sb_if.md_busy); end
            tick();
        end
        #1;
        total++; if (sb_if.md_busy !== 1'b0) begin bad++; $display("FAIL mult_done got=%0d want=0", sb_if.md_busy); end
    endtask

    task automatic test_reset_mid();
        flush();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);          // div -> 10
        tick();
        idle();                                             // -> 9
        tick();
        set_d(0, 0, 0, 0, 0, 0, 1, 9, 2, 0, 0, 0);          // lw $9 -> 8
        tick();
        set_d(0, 0, 0, 0, 0, 0, 1, 31, 0, 0, 0, 0);         // jal -> 7, lw in M
        tick();
        set_d(31, 1, 0, 9, 1, 0, 0, 0, 0, 0, 0, 1);
        #1;
        total++; if (sb_if.md_busy !== 1'b1) begin bad++; $display("FAIL mid_pre_busy got=%0d want=1", sb_if.md_busy); end
        total++; if (sb_if.stall !== 1'b1) begin bad++; $display("FAIL mid_pre_stall got=%0d want=1", sb_if.stall); end
        total++; if (sb_if.fwd_d_rs !== 2'd3) begin bad++; $display("FAIL mid_pre_fwd got=%0d want=3", sb_if.fwd_d_rs); end
        reset = 1'b0;
        #1;
        total++; if (sb_if.md_busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%0d want=0", sb_if.md_busy); end
        total++; if (sb_if.stall !== 1'b0) begin bad++; $display("FAIL mid_stall got=%0d want=0", sb_if.stall); end
        total++; if (sb_if.fwd_d_rs !== 2'd0) begin bad++; $display("FAIL mid_fwd_rs got=%0d want=0", sb_if.fwd_d_rs); end
        total++; if (sb_if.fwd_d_rt !== 2'd0) begin bad++; $display("FAIL mid_fwd_rt got=%0d want=0", sb_if.fwd_d_rt); end
        tick();
        reset = 1'b1;
        tick();
        #1;
        total++; if (sb_if.fwd_d_rs !== 2'd0) begin bad++; $display("FAIL mid_after_fwd got=%0d want=0", sb_if.fwd_d_rs); end
        total++; if (sb_if.md_busy !== 1'b0) begin bad++; $display("FAIL mid_after_busy got=%0d want=0", sb_if.md_busy); end
        idle();
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_store_fwd();
        test_jal();
        test_zero_nouse();
        test_md();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
